// File: rtl/dac_serial_ctrl_pkg.sv
// Shared constants and state encoding for the serial DAC write controller.
package dac_serial_ctrl_pkg;

    localparam int DW           = 16;
    localparam int SCLK_DIV_DEF = 4;
    localparam int LDAC_LOW_DEF = 2;
    localparam int RST_HOLD_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CS_END = 2'd2,
        LOAD   = 2'd3
    } state_t;

endpackage

// File: rtl/dac_serial_ctrl_if.sv
// Sample input plus DAC pin bundle for dac_serial_ctrl.
//
// Handshake: din_vld is a single-cycle strobe with din valid in the same
// cycle. There is no ready signal; the controller accepts a strobe only
// while it is in IDLE, and strobes arriving at any other time are dropped.
// state is a debug view of the controller FSM.
interface dac_serial_ctrl_if;
    import dac_serial_ctrl_pkg::*;

    logic [DW-1:0] din;
    logic          din_vld;
    logic          cs;
    logic          sclk;
    logic          sdi;
    logic          ldac;
    state_t        state;

    modport master (
        output din, din_vld,
        input  cs, sclk, sdi, ldac, state
    );

    modport slave (
        input  din, din_vld,
        output cs, sclk, sdi, ldac, state
    );

endinterface

// File: rtl/dac_rst_hold.sv
// Reset conditioner: asserts immediately on rst_n low and keeps the internal
// reset high for RST_HOLD cycles after rst_n is first sampled high.
module dac_rst_hold #(
    parameter int RST_HOLD = dac_serial_ctrl_pkg::RST_HOLD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst
);
    logic [7:0] cnt;
    logic       hold;

    // Reload the hold counter while rst_n is low, count it down afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= 8'(RST_HOLD);
            hold <= 1'b1;
        end else if (cnt != 8'd0) begin
            cnt  <= cnt - 8'd1;
            hold <= 1'b1;
        end else begin
            hold <= 1'b0;
        end
    end

    // rst_n acts on the same edge it is sampled; hold covers the tail.
    assign rst = !rst_n || hold;

endmodule

// File: rtl/dac_serial_ctrl.sv
// Serial write controller for a 16-bit SPI-style DAC with an LDAC strobe.
// Shifts a latched sample MSB-first, closes cs, then pulses ldac low.
module dac_serial_ctrl #(
    parameter int SCLK_DIV = dac_serial_ctrl_pkg::SCLK_DIV_DEF,
    parameter int LDAC_LOW = dac_serial_ctrl_pkg::LDAC_LOW_DEF,
    parameter int RST_HOLD = dac_serial_ctrl_pkg::RST_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    dac_serial_ctrl_if.slave bus
);
    import dac_serial_ctrl_pkg::*;

    localparam int HALF  = SCLK_DIV / 2;
    localparam int BIT_W = $clog2(DW);

    logic             rst;
    state_t           state;
    logic [DW-1:0]    shreg;
    logic [7:0]       div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       load_cnt;
    logic             cs_q;
    logic             sclk_q;
    logic             ldac_q;

    dac_rst_hold #(.RST_HOLD(RST_HOLD)) u_rst_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .rst   (rst)
    );

    // Frame sequencer: latch, shift 16 bits, close cs, pulse ldac.
    // sdi is the MSB of the shift register, so it only moves at bit
    // boundaries, which always fall in the low half of sclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            load_cnt <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            ldac_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.din_vld) begin
                        state   <= SHIFT;
                        shreg   <= bus.din;
                        cs_q    <= 1'b0;
                        sclk_q  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (div_cnt == 8'(SCLK_DIV - 1)) begin
                        sclk_q  <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt == BIT_W'(DW - 1)) begin
                            state   <= CS_END;
                            cs_q    <= 1'b1;
                            shreg   <= '0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= {shreg[DW-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                        sclk_q  <= ((div_cnt + 8'd1) >= 8'(HALF));
                    end
                end
                CS_END: begin
                    state    <= LOAD;
                    ldac_q   <= 1'b0;
                    load_cnt <= '0;
                end
                LOAD: begin
                    if (load_cnt == 8'(LDAC_LOW - 1)) begin
                        state    <= IDLE;
                        ldac_q   <= 1'b1;
                        load_cnt <= '0;
                    end else begin
                        load_cnt <= load_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cs    = cs_q;
    assign bus.sclk  = sclk_q;
    assign bus.sdi   = shreg[DW-1];
    assign bus.ldac  = ldac_q;
    assign bus.state = state;

endmodule

// File: tb/tb_dac_serial_ctrl.sv
// Bench for dac_serial_ctrl: default instance plus SCLK_DIV=2 and 8 variants.
module tb_dac_serial_ctrl;
  import dac_serial_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic [15:0] din = '0;
  logic        din_vld = 1'b0;
  logic [2:0]  en = 3'b001;

  dac_serial_ctrl_if bus0();
  dac_serial_ctrl_if bus1();
  dac_serial_ctrl_if bus2();

  assign bus0.din = din;
  assign bus1.din = din;
  assign bus2.din = din;
  assign bus0.din_vld = din_vld & en[0];
  assign bus1.din_vld = din_vld & en[1];
  assign bus2.din_vld = din_vld & en[2];

  dac_serial_ctrl #(.SCLK_DIV(4), .LDAC_LOW(2), .RST_HOLD(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  dac_serial_ctrl #(.SCLK_DIV(2), .LDAC_LOW(1), .RST_HOLD(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  dac_serial_ctrl #(.SCLK_DIV(8), .LDAC_LOW(1), .RST_HOLD(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  logic [2:0] cs_w, sclk_w, sdi_w, ldac_w;
  assign cs_w   = {bus2.cs, bus1.cs, bus0.cs};
  assign sclk_w = {bus2.sclk, bus1.sclk, bus0.sclk};
  assign sdi_w  = {bus2.sdi, bus1.sdi, bus0.sdi};
  assign ldac_w = {bus2.ldac, bus1.ldac, bus0.ldac};

  int div_a[3] = '{4, 2, 8};
  int ldl_a[3] = '{2, 1, 1};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  int n_push[3] = '{0, 0, 0};

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got=%0h expected=%0h", name, d, cyc, got, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] w);
    n_push[d]++;
    case (d)
      0: exp_q0.push_back(w);
      1: exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endtask

  function automatic int q_size(input int d);
    case (d)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [15:0] q_pop(input int d);
    case (d)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  // ---------------- pin monitor (mid-cycle sampling) ----------------
  bit          mon_on = 1'b0;
  bit          in_frame[3], wait_ldac[3], seen_rise[3];
  logic        prev_cs[3], prev_sclk[3], prev_sdi[3], prev_ldac[3];
  int          cs_len[3], hi_cnt[3], nbits[3], lw[3], rise_cyc[3];
  int          ldac_pulses[3] = '{0, 0, 0};
  logic [15:0] word[3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (mon_on) begin
        if (!rst_n) begin
          in_frame[d]  = 1'b0;
          wait_ldac[d] = 1'b0;
          seen_rise[d] = 1'b0;
        end else begin
          if (prev_cs[d] && !cs_w[d]) begin
            if (seen_rise[d]) chk("cs_gap_ge3", d, 32'((cyc - rise_cyc[d]) >= 3), 32'd1);
            in_frame[d] = 1'b1;
            cs_len[d] = 0; hi_cnt[d] = 0; nbits[d] = 0; word[d] = '0;
          end
          if (in_frame[d] && !cs_w[d]) begin
            cs_len[d]++;
            if (sclk_w[d]) hi_cnt[d]++;
            if (!prev_sclk[d] && sclk_w[d]) begin
              word[d] = {word[d][14:0], sdi_w[d]};
              nbits[d]++;
            end
            if (prev_sclk[d] && sclk_w[d]) chk("sdi_stable_hi", d, 32'(sdi_w[d]), 32'(prev_sdi[d]));
          end
          if (in_frame[d] && !prev_cs[d] && cs_w[d]) begin
            in_frame[d] = 1'b0;
            chk("cs_low_len", d, cs_len[d], 16 * div_a[d]);
            chk("sclk_high_cnt", d, hi_cnt[d], 8 * div_a[d]);
            chk("sclk_rises", d, nbits[d], 16);
            if (q_size(d) == 0) begin
              n_cmp++; n_err++;
              $display("FAIL frame_word dut%0d @cyc %0d: got=%0h expected=none", d, cyc, word[d]);
            end else begin
              chk("frame_word", d, word[d], q_pop(d));
            end
            chk("cs_end_sdi_sclk", d, {sdi_w[d], sclk_w[d]}, 2'b00);
            rise_cyc[d]  = cyc;
            seen_rise[d] = 1'b1;
            wait_ldac[d] = 1'b1;
          end
          if (prev_ldac[d] && !ldac_w[d]) begin
            ldac_pulses[d]++;
            chk("ldac_expected", d, 32'(wait_ldac[d]), 32'd1);
            if (wait_ldac[d]) chk("ldac_delay", d, cyc - rise_cyc[d], 1);
            wait_ldac[d] = 1'b0;
            lw[d] = 0;
          end
          if (!ldac_w[d]) lw[d]++;
          if (!prev_ldac[d] && ldac_w[d]) chk("ldac_width", d, lw[d], ldl_a[d]);
        end
      end
      prev_cs[d]   = cs_w[d];
      prev_sclk[d] = sclk_w[d];
      prev_sdi[d]  = sdi_w[d];
      prev_ldac[d] = ldac_w[d];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] w);
    din = w;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    din = 16'($urandom_range(0, 65535));
  endtask

  typedef struct {
    logic [15:0] din;
    int          delay;
    logic        accept;
    logic        exp_cs;
  } vec_t;

  vec_t tbl[7];

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] w;
    int p0;

    tbl[0] = '{16'hC5F2, 5,  1'b1, 1'b0};  // single write
    tbl[1] = '{16'h0001, 10, 1'b0, 1'b0};  // busy: dropped at T+10
    tbl[2] = '{16'hA5A5, 58, 1'b1, 1'b0};  // earliest accept, T+68
    tbl[3] = '{16'hFFFF, 68, 1'b1, 1'b0};  // back-to-back
    tbl[4] = '{16'h0000, 68, 1'b1, 1'b0};
    tbl[5] = '{16'h1234, 67, 1'b0, 1'b1};  // one cycle early: in LOAD
    tbl[6] = '{16'h8001, 1,  1'b1, 1'b0};  // then accepted at T+68

    // Reset held 10 cycles: all outputs at reset values.
    repeat (10) begin
      tick();
      chk("rst_outputs", 0, {bus2.cs, bus2.sclk, bus2.sdi, bus2.ldac,
                             bus1.cs, bus1.sclk, bus1.sdi, bus1.ldac,
                             bus0.cs, bus0.sclk, bus0.sdi, bus0.ldac}, 12'h999);
      chk("rst_state", 0, 32'(bus0.state), 32'(IDLE));
    end

    // Release; strobes during the hold window must be ignored.
    rst_n = 1'b1;
    din = 16'hDEAD;
    din_vld = 1'b1;
    repeat (5) begin
      tick();
      chk("hold_cs", 0, 32'(bus0.cs), 32'd1);
    end
    din_vld = 1'b0;
    repeat (3) begin
      tick();
      chk("hold_after_cs", 0, {bus0.cs, bus0.ldac}, 2'b11);
    end
    mon_on = 1'b1;

    // Table-driven writes on the default instance.
    for (int i = 0; i < 7; i++) begin
      repeat (tbl[i].delay - 1) tick();
      strobe(tbl[i].din);
      if (tbl[i].accept) push(0, tbl[i].din);
      chk("accept_cs", 0, 32'(bus0.cs), 32'(tbl[i].exp_cs));
    end
    repeat (80) tick();

    // Reset mid-transfer at T+30: abort, no ldac pulse, then clean write.
    strobe(16'hBEEF);
    repeat (29) tick();
    p0 = ldac_pulses[0];
    rst_n = 1'b0;
    tick();
    chk("abort_outputs", 0, {bus0.cs, bus0.sclk, bus0.sdi, bus0.ldac}, 4'b1001);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("abort_no_ldac", 0, ldac_pulses[0], p0);
    strobe(16'h3C5A);
    push(0, 16'h3C5A);
    chk("post_abort_cs", 0, 32'(bus0.cs), 32'd0);
    repeat (75) tick();
    chk("post_abort_ldac", 0, ldac_pulses[0], p0 + 1);

    // Parameter sweep: SCLK_DIV=2 and 8 with LDAC_LOW=1.
    en = 3'b110;
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom_range(0, 65535));
      strobe(w);
      push(1, w);
      push(2, w);
      repeat (139) tick();
    end

    // Earliest accept for SCLK_DIV=2, LDAC_LOW=1: T+35.
    en = 3'b010;
    w = 16'($urandom_range(0, 65535));
    strobe(w);
    push(1, w);
    repeat (34) tick();
    w = 16'($urandom_range(0, 65535));
    strobe(w);
    push(1, w);
    chk("div2_earliest_cs", 1, 32'(bus1.cs), 32'd0);
    repeat (60) tick();

    // Drain and final bookkeeping.
    for (int d = 0; d < 3; d++) begin
      chk("queue_empty", d, q_size(d), 0);
      chk("ldac_pulse_total", d, ldac_pulses[d], n_push[d]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dac_serial_ctrl.md
Name: dac_serial_ctrl

Overview:
- Serial write controller for a 16-bit SPI-style DAC with a load strobe (LDAC).
- Accepts a parallel sample with a one-cycle valid strobe and shifts it out MSB-first on cs/sclk/sdi.
- After the shift, pulses ldac low to update the DAC output.
- Sits between the sample-producing logic and the DAC pins; contains its own reset-conditioning stage.

Parameters:
- SCLK_DIV, 4: system clocks per sclk period; even, ≥2.
- LDAC_LOW, 2: ldac low-pulse width in clk cycles; ≥1.
- RST_HOLD, 4: cycles the internal reset stays asserted after rst_n returns high; ≥1.
- DW, 16: data word width. Fixed at 16.

Ports:
- clk      in   1   system clock (50 MHz nominal).
- rst_n    in   1   reset, synchronous, active-low.
- din      in   16  sample to write.
- din_vld  in   1   one-cycle strobe; din is valid in the same cycle.
- cs       out  1   DAC chip select, active-low.
- sclk     out  1   serial clock; idles low.
- sdi      out  1   serial data, MSB first.
- ldac     out  1   DAC load strobe, active-low.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Internal reset:
  - rst_n=0 sampled on a clk edge asserts the internal reset at that edge.
  - After rst_n is sampled 1, the internal reset stays asserted for RST_HOLD further cycles.
  - All other logic is reset only by this internal reset.
- Reset values: cs=1, sclk=0, sdi=0, ldac=1, state=IDLE, shift register and counters 0. All outputs are registered.
- State machine:
  - IDLE: waits for din_vld.
  - SHIFT: transfers 16 bits.
  - CS_END: 1 cycle, cs returns high.
  - LOAD: ldac is low.
- Transfer timing (T = cycle in which din_vld=1 is sampled in IDLE):
  - At T, din is latched.
  - T+1 .. T+16·SCLK_DIV: cs=0.
  - Bit k (k=0..15) occupies cycles T+1+k·SCLK_DIV onward, for SCLK_DIV cycles.
  - Within each bit: sdi=din[15-k] for all SCLK_DIV cycles; sclk=0 for the first SCLK_DIV/2 cycles and 1 for the second half.
  - sdi changes only while sclk is low; the DAC samples on the sclk rising edge.
- After the last bit:
  - T+16·SCLK_DIV+1: CS_END; cs=1, sclk=0, sdi=0.
  - Next LDAC_LOW cycles: LOAD; ldac=0.
  - Then IDLE with ldac=1.
- The first din_vld that can be accepted is at T+16·SCLK_DIV+2+LDAC_LOW.
- din_vld outside IDLE is ignored; there is no queuing. din changes after T do not affect the transfer in progress.
- Reset mid-transfer: the transfer aborts and outputs return to reset values on the reset edge. No partial ldac pulse is issued.
- Default timing (SCLK_DIV=4, LDAC_LOW=2):
  - cs low T+1..T+64, high at T+65.
  - ldac low T+66..T+67.
  - Next accept at T+68.

Decomposition:
- Shared package: DW, default SCLK_DIV/LDAC_LOW/RST_HOLD constants, and the state enum (IDLE, SHIFT, CS_END, LOAD).
- One sub-module, dac_rst_hold: the RST_HOLD reset stretcher.
- The shift FSM stays in the top module.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles then release -> cs=1, sclk=0, sdi=0, ldac=1 throughout reset and for RST_HOLD cycles after; din_vld pulses during that window are ignored.
- Single write: din=16'hC5F2, din_vld pulsed 1 cycle at cycle 100 -> cs low for 64 cycles; sdi bits on 16 sclk rising edges = 1100_0101_1111_0010; ldac low 2 cycles starting 2 cycles after the last sclk period ends.
- Busy rejection: a second din_vld with din=16'h0001 at T+10 -> ignored, only 0xC5F2 shifted; a din_vld at T+68 is accepted.
- Back-to-back: din=16'hFFFF then 16'h0000, each strobed at its earliest accept cycle -> sdi all ones then all zeros; exactly two ldac pulses; cs high for ≥3 cycles between frames.
- Reset mid-transfer: rst_n=0 at T+30 -> cs=1, sclk=0 at the next edge; no ldac pulse; a fresh write after release completes normally.
- Parameter sweep: SCLK_DIV=2 and 8, LDAC_LOW=1 -> cs-low length 16·SCLK_DIV cycles, sclk duty 50%, ldac width = LDAC_LOW.
